// File: rtl/coord_promedio_pkg.sv
// Shared definitions for the coordinate averaging block: widths, state
// encoding, default window size / spread threshold and the spread test.
package coord_promedio_pkg;

   localparam int                 COORD_W    = 12;
   localparam int                 N_LOG2_DEF = 2;
   localparam logic [COORD_W-1:0] UMBRAL_DEF = 12'd64;

   typedef enum logic {
      ACUM = 1'b0,
      EVAL = 1'b1
   } estado_t;

   // True when the spread of one axis (max - min) is within the threshold.
   // max >= min always holds inside a window, so the subtraction never wraps.
   function automatic logic dentro_umbral(input logic [COORD_W-1:0] maximo,
                                          input logic [COORD_W-1:0] minimo,
                                          input logic [COORD_W-1:0] umbral);
      logic [COORD_W-1:0] rango;
      rango = maximo - minimo;
      return (rango <= umbral);
   endfunction

endpackage

// File: rtl/coord_promedio_if.sv
// Coordinate stream from the ADC controller and averaged result towards the
// application logic.
interface coord_promedio_if;
   import coord_promedio_pkg::*;

   logic               COORD_VALID;
   logic [COORD_W-1:0] X_IN;
   logic [COORD_W-1:0] Y_IN;
   logic               PEN_UP;
   logic [COORD_W-1:0] X_OUT;
   logic [COORD_W-1:0] Y_OUT;
   logic               OUT_VALID;
   logic               RECHAZO;

   modport master (
      output COORD_VALID, X_IN, Y_IN, PEN_UP,
      input  X_OUT, Y_OUT, OUT_VALID, RECHAZO
   );

   modport slave (
      input  COORD_VALID, X_IN, Y_IN, PEN_UP,
      output X_OUT, Y_OUT, OUT_VALID, RECHAZO
   );

endinterface

// File: rtl/coord_promedio_eje_acum.sv
// Per-axis window accumulator: running sum plus running min/max.
// carga_i starts a new window with the sample, acum_i folds the sample in.
module eje_acum
   import coord_promedio_pkg::*;
#(
   parameter int N_LOG2 = N_LOG2_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      carga_i,
   input  logic                      acum_i,
   input  logic [COORD_W-1:0]        dato_i,
   output logic [COORD_W+N_LOG2-1:0] suma_o,
   output logic [COORD_W-1:0]        min_o,
   output logic [COORD_W-1:0]        max_o
);

   localparam int SUMA_W = COORD_W + N_LOG2;

   logic [SUMA_W-1:0]  suma_q, suma_d;
   logic [COORD_W-1:0] min_q, min_d;
   logic [COORD_W-1:0] max_q, max_d;

   // Next sum/min/max: load on the first sample, accumulate afterwards.
   always_comb begin
      suma_d = suma_q;
      min_d  = min_q;
      max_d  = max_q;
      if (carga_i) begin
         suma_d = SUMA_W'(dato_i);
         min_d  = dato_i;
         max_d  = dato_i;
      end else if (acum_i) begin
         suma_d = suma_q + SUMA_W'(dato_i);
         if (dato_i < min_q) begin
            min_d = dato_i;
         end else begin
            min_d = min_q;
         end
         if (dato_i > max_q) begin
            max_d = dato_i;
         end else begin
            max_d = max_q;
         end
      end else begin
         suma_d = suma_q;
      end
   end

   // Accumulator registers, cleared by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         suma_q <= {SUMA_W{1'b0}};
         min_q  <= {COORD_W{1'b0}};
         max_q  <= {COORD_W{1'b0}};
      end else begin
         suma_q <= suma_d;
         min_q  <= min_d;
         max_q  <= max_d;
      end
   end

   assign suma_o = suma_q;
   assign min_o  = min_q;
   assign max_o  = max_q;

endmodule

// File: rtl/coord_promedio.sv
// Averages windows of 2^N_LOG2 touch coordinates, discarding windows whose
// per-axis spread exceeds UMBRAL. Pen-up abandons a partial window silently.
module coord_promedio
   import coord_promedio_pkg::*;
#(
   parameter int                 N_LOG2 = N_LOG2_DEF,
   parameter logic [COORD_W-1:0] UMBRAL = UMBRAL_DEF
) (
   input logic             CLK,
   input logic             RST,
   coord_promedio_if.slave bus
);

   localparam int                SUMA_W   = COORD_W + N_LOG2;
   localparam logic [N_LOG2-1:0] CNT_CERO = {N_LOG2{1'b0}};
   localparam logic [N_LOG2-1:0] CNT_UNO  = N_LOG2'(1'b1);
   localparam logic [N_LOG2-1:0] CNT_ULT  = {N_LOG2{1'b1}};

   estado_t            estado_q, estado_d;
   logic [N_LOG2-1:0]  cnt_q, cnt_d;
   logic [COORD_W-1:0] x_out_q, x_out_d;
   logic [COORD_W-1:0] y_out_q, y_out_d;
   logic               out_valid_q, out_valid_d;
   logic               rechazo_q, rechazo_d;

   logic               carga_s;
   logic               acum_s;
   logic [SUMA_W-1:0]  suma_x_s, suma_y_s;
   logic [COORD_W-1:0] min_x_s, max_x_s, min_y_s, max_y_s;

   eje_acum #(.N_LOG2(N_LOG2)) u_eje_x (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .carga_i (carga_s),
      .acum_i  (acum_s),
      .dato_i  (bus.X_IN),
      .suma_o  (suma_x_s),
      .min_o   (min_x_s),
      .max_o   (max_x_s)
   );

   eje_acum #(.N_LOG2(N_LOG2)) u_eje_y (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .carga_i (carga_s),
      .acum_i  (acum_s),
      .dato_i  (bus.Y_IN),
      .suma_o  (suma_y_s),
      .min_o   (min_y_s),
      .max_o   (max_y_s)
   );

   // Next state, sample counter, accumulator controls and output registers.
   // The counter wraps to zero on the last sample of a window, so a sample
   // arriving during EVAL naturally loads as the first of the next window.
   always_comb begin
      estado_d    = estado_q;
      cnt_d       = cnt_q;
      carga_s     = 1'b0;
      acum_s      = 1'b0;
      x_out_d     = x_out_q;
      y_out_d     = y_out_q;
      out_valid_d = 1'b0;
      rechazo_d   = 1'b0;
      if (bus.PEN_UP) begin
         estado_d = ACUM;
         cnt_d    = CNT_CERO;
      end else begin
         case (estado_q)
            ACUM: begin
               if (bus.COORD_VALID && (cnt_q == CNT_ULT)) begin
                  estado_d = EVAL;
               end else begin
                  estado_d = ACUM;
               end
            end
            EVAL: begin
               estado_d = ACUM;
               if (dentro_umbral(max_x_s, min_x_s, UMBRAL) &&
                   dentro_umbral(max_y_s, min_y_s, UMBRAL)) begin
                  x_out_d     = COORD_W'(suma_x_s >> N_LOG2);
                  y_out_d     = COORD_W'(suma_y_s >> N_LOG2);
                  out_valid_d = 1'b1;
               end else begin
                  rechazo_d = 1'b1;
               end
            end
            default: begin
               estado_d = ACUM;
            end
         endcase
         if (bus.COORD_VALID) begin
            if (cnt_q == CNT_CERO) begin
               carga_s = 1'b1;
            end else begin
               acum_s = 1'b1;
            end
            cnt_d = cnt_q + CNT_UNO;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         estado_q    <= ACUM;
         cnt_q       <= CNT_CERO;
         x_out_q     <= {COORD_W{1'b0}};
         y_out_q     <= {COORD_W{1'b0}};
         out_valid_q <= 1'b0;
         rechazo_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
         out_valid_q <= out_valid_d;
         rechazo_q   <= rechazo_d;
      end
   end

   assign bus.X_OUT     = x_out_q;
   assign bus.Y_OUT     = y_out_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.RECHAZO   = rechazo_q;

endmodule

// File: tb/tb_coord_promedio.sv
// Directed bench for coord_promedio: a table of complete windows plus
// hand-written sequences for pen-up, back-to-back and reset corner cases.
module tb_coord_promedio;

   typedef struct packed {
      logic [3:0][11:0] xs;
      logic [3:0][11:0] ys;
      logic             acepta;
      logic [11:0]      ex;
      logic [11:0]      ey;
   } ventana_t;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_errors;

   ventana_t tabla [8];

   coord_promedio_if bus ();

   coord_promedio #(.N_LOG2(2), .UMBRAL(12'd64)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic ventana_t mk(input logic [11:0] x0, x1, x2, x3,
                                   input logic [11:0] y0, y1, y2, y3,
                                   input logic acepta,
                                   input logic [11:0] ex, ey);
      ventana_t v;
      v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
      v.ys[0] = y0; v.ys[1] = y1; v.ys[2] = y2; v.ys[3] = y3;
      v.acepta = acepta;
      v.ex = ex;
      v.ey = ey;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [11:0] x, input logic [11:0] y);
      bus.COORD_VALID = 1'b1;
      bus.X_IN        = x;
      bus.Y_IN        = y;
      step();
      bus.COORD_VALID = 1'b0;
   endtask

   task automatic check_quiet(input string nm);
      check({nm, "_pulses"}, {30'd0, bus.OUT_VALID, bus.RECHAZO}, 32'd0);
   endtask

   // Called right after the 4th sample: EVAL cycle, result cycle, cycle after.
   task automatic expect_window(input string nm, input logic acepta,
                                input logic [11:0] ex, input logic [11:0] ey);
      check_quiet({nm, "_eval"});
      step();
      check({nm, "_out_valid"}, {31'd0, bus.OUT_VALID}, {31'd0, acepta});
      check({nm, "_rechazo"},   {31'd0, bus.RECHAZO},   {31'd0, ~acepta});
      check({nm, "_x_out"},     {20'd0, bus.X_OUT},     {20'd0, ex});
      check({nm, "_y_out"},     {20'd0, bus.Y_OUT},     {20'd0, ey});
      step();
      check_quiet({nm, "_after"});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      RST             = 1'b0;
      bus.COORD_VALID = 1'b0;
      bus.X_IN        = 12'd0;
      bus.Y_IN        = 12'd0;
      bus.PEN_UP      = 1'b0;

      tabla[0] = mk(12'd100, 12'd104, 12'd108, 12'd112, 12'd200, 12'd200, 12'd201, 12'd203, 1'b1, 12'd106, 12'd201);
      tabla[1] = mk(12'd100, 12'd100, 12'd100, 12'd300, 12'd50, 12'd50, 12'd50, 12'd50, 1'b0, 12'd106, 12'd201);
      tabla[2] = mk(12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1, 12'd4095, 12'd4095);
      tabla[3] = mk(12'd0, 12'd64, 12'd0, 12'd64, 12'd1000, 12'd1000, 12'd1000, 12'd1000, 1'b1, 12'd32, 12'd1000);
      tabla[4] = mk(12'd0, 12'd65, 12'd0, 12'd0, 12'd1000, 12'd1000, 12'd1000, 12'd1000, 1'b0, 12'd32, 12'd1000);
      tabla[5] = mk(12'd5, 12'd5, 12'd5, 12'd5, 12'd0, 12'd0, 12'd0, 12'd65, 1'b0, 12'd32, 12'd1000);
      tabla[6] = mk(12'd1, 12'd1, 12'd1, 12'd2, 12'd7, 12'd8, 12'd8, 12'd8, 1'b1, 12'd1, 12'd7);
      tabla[7] = mk(12'd3000, 12'd3000, 12'd3000, 12'd3000, 12'd10, 12'd74, 12'd10, 12'd74, 1'b1, 12'd3000, 12'd42);

      // Reset state
      step();
      step();
      check("rst_x_out", {20'd0, bus.X_OUT}, 32'd0);
      check("rst_y_out", {20'd0, bus.Y_OUT}, 32'd0);
      check_quiet("rst");
      RST = 1'b1;
      step();

      // Table of complete windows
      for (int w = 0; w < 8; w++) begin
         for (int s = 0; s < 4; s++) begin
            send(tabla[w].xs[s], tabla[w].ys[s]);
         end
         expect_window($sformatf("win%0d", w), tabla[w].acepta, tabla[w].ex, tabla[w].ey);
      end

      // Pen-up abort of a partial window
      send(12'd500, 12'd500);
      send(12'd500, 12'd500);
      bus.PEN_UP = 1'b1;
      step();
      bus.PEN_UP = 1'b0;
      check_quiet("penup_cycle");
      send(12'd10, 12'd10);
      send(12'd10, 12'd10);
      send(12'd10, 12'd10);
      send(12'd14, 12'd14);
      expect_window("penup", 1'b1, 12'd11, 12'd11);

      // PEN_UP together with what would be the 4th sample
      send(12'd2000, 12'd2000);
      send(12'd2000, 12'd2000);
      send(12'd2000, 12'd2000);
      bus.COORD_VALID = 1'b1;
      bus.PEN_UP      = 1'b1;
      bus.X_IN        = 12'd2000;
      bus.Y_IN        = 12'd2000;
      step();
      bus.COORD_VALID = 1'b0;
      bus.PEN_UP      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_quiet($sformatf("samecyc_q%0d", i));
         step();
      end
      send(12'd20, 12'd20);
      send(12'd20, 12'd20);
      send(12'd20, 12'd20);
      send(12'd24, 12'd24);
      expect_window("samecyc", 1'b1, 12'd21, 12'd21);

      // Back-to-back windows: first sample of the second lands in EVAL
      for (int i = 0; i < 4; i++) send(12'd40, 12'd40);
      check_quiet("b2b_eval1");
      send(12'd80, 12'd80);
      check("b2b_ov1", {31'd0, bus.OUT_VALID}, 32'd1);
      check("b2b_x1", {20'd0, bus.X_OUT}, 32'd40);
      send(12'd80, 12'd80);
      check_quiet("b2b_after1");
      send(12'd80, 12'd80);
      send(12'd84, 12'd84);
      expect_window("b2b_w2", 1'b1, 12'd81, 12'd81);

      // PEN_UP during EVAL cancels the result
      for (int i = 0; i < 4; i++) send(12'd50, 12'd50);
      bus.PEN_UP = 1'b1;
      step();
      bus.PEN_UP = 1'b0;
      check_quiet("peneval_q0");
      check("peneval_x", {20'd0, bus.X_OUT}, 32'd81);
      step();
      check_quiet("peneval_q1");

      // Reset mid-window after 3 samples
      for (int i = 0; i < 3; i++) send(12'd900, 12'd900);
      RST = 1'b0;
      #1;
      check("rstmid_x", {20'd0, bus.X_OUT}, 32'd0);
      check("rstmid_y", {20'd0, bus.Y_OUT}, 32'd0);
      check_quiet("rstmid");
      step();
      RST = 1'b1;
      check_quiet("rstmid_rel0");
      step();
      check_quiet("rstmid_rel1");
      for (int i = 0; i < 4; i++) send(12'd300, 12'd300);
      expect_window("rstmid_next", 1'b1, 12'd300, 12'd300);

      // Reset during EVAL
      for (int i = 0; i < 4; i++) send(12'd700, 12'd700);
      RST = 1'b0;
      #1;
      check("rsteval_x", {20'd0, bus.X_OUT}, 32'd0);
      check_quiet("rsteval");
      step();
      RST = 1'b1;
      check_quiet("rsteval_rel0");
      step();
      check_quiet("rsteval_rel1");
      check("rsteval_x_hold", {20'd0, bus.X_OUT}, 32'd0);
      send(12'd1, 12'd4095);
      send(12'd2, 12'd4095);
      send(12'd3, 12'd4095);
      send(12'd4, 12'd4095);
      expect_window("rsteval_next", 1'b1, 12'd2, 12'd4095);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/coord_promedio.md
# coord_promedio

Downstream of the touch-screen ADC controller: consumes each completed 12-bit X/Y coordinate pair, accumulates a window of 2^N_LOG2 pairs, rejects noisy windows by per-axis spread, and emits one averaged coordinate pair per accepted window. It sits between the controller's X_COORD/Y_COORD outputs and the application logic. Pen-up aborts any partial window.

## Interface
- N_LOG2, 2: log2 of window size N (N = 4 by default); legal range 1..4.
- UMBRAL, 12'd64: maximum allowed (max − min) per axis within a window.
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- COORD_VALID  input  1  one-cycle pulse: X_IN/Y_IN hold a new pair.
- X_IN  input  12  X coordinate from controller.
- Y_IN  input  12  Y coordinate from controller.
- PEN_UP  input  1  level, high while no touch; aborts the current window.
- X_OUT  output  12  averaged X, registered, held until the next accepted window.
- Y_OUT  output  12  averaged Y, same rules as X_OUT.
- OUT_VALID  output  1  one-cycle pulse: X_OUT/Y_OUT updated.
- RECHAZO  output  1  one-cycle pulse: window discarded because of spread.

## Operation
- Reset (RST low, asynchronous): state ACUM, count 0, accumulators and min/max cleared, X_OUT = Y_OUT = 0, OUT_VALID = RECHAZO = 0.
- States: ACUM, EVAL.
- ACUM, on COORD_VALID: if count == 0, then sum = input and min = max = input; otherwise sum += input and min/max update (per axis). Count increments. When the accepted sample is number N (count was N−1), the next state is EVAL.
- Sum width is 12+N_LOG2 bits, so there is no overflow; min and max are 12 bits each.
- EVAL (exactly one cycle):
  - If (maxX − minX) ≤ UMBRAL and (maxY − minY) ≤ UMBRAL, register X_OUT = sumX >> N_LOG2 and Y_OUT = sumY >> N_LOG2 (truncating) and pulse OUT_VALID.
  - Otherwise pulse RECHAZO and leave X_OUT/Y_OUT unchanged.
  - In both cases, return to ACUM.
- COORD_VALID during EVAL: the sample becomes sample 1 of the next window (count = 1, accumulators loaded with it). It is never dropped.
- PEN_UP high in any cycle: count is forced to 0 and the state to ACUM. No OUT_VALID or RECHAZO is produced for the partial window. PEN_UP has priority over COORD_VALID in the same cycle, and that sample is discarded.
- PEN_UP high during EVAL: the evaluation is cancelled and no pulse is produced.
- Outputs never change except on an OUT_VALID pulse or on reset.

## Timing
- Cycle k is the cycle in which the Nth COORD_VALID is sampled. The state is EVAL in cycle k+1. OUT_VALID or RECHAZO is high in cycle k+2, coincident with the new X_OUT/Y_OUT values.
- Latency from the last sample to the output is 2 cycles.
- Throughput: one sample per cycle; back-to-back windows are supported with no dead cycle.
- OUT_VALID and RECHAZO are mutually exclusive and each is exactly one cycle wide.
- Reset asserted mid-window or during EVAL: all state is cleared immediately, and no pulse is produced after reset release.

## Structure
- Shared package holds: coordinate width constant (12), state encoding (ACUM, EVAL), default N_LOG2 and UMBRAL.
- Sub-module eje_acum (per axis: sum, min, max, load/accumulate/clear controls) is instantiated twice, for X and Y.
- The top level holds the FSM, the counter, the spread comparison and the output registers.

## Test plan
- Accepted window: X = 100, 104, 108, 112 and Y = 200, 200, 201, 203, sent back-to-back. Required: OUT_VALID 2 cycles after the 4th sample, X_OUT = 106, Y_OUT = 201.
- Spread rejection: X = 100, 100, 100, 300 with Y constant at 50. Required: RECHAZO pulse, no OUT_VALID, X_OUT/Y_OUT keep their previous values.
- Pen-up abort: send 2 samples of 500, assert PEN_UP for 1 cycle, then send X = Y = 10, 10, 10, 14. Required: a single OUT_VALID with X_OUT = Y_OUT = 11.
- Same-cycle PEN_UP and COORD_VALID on what would be the 4th sample: no output is produced, and the next 4 samples form a fresh window.
- Full scale: four samples of 4095 on both axes. Required: X_OUT = Y_OUT = 4095, no wrap.
- Reset mid-window (after 3 samples) and reset during EVAL: all outputs read 0, no pulses appear, and the next full window averages correctly.
